// File: rtl/ntt_lane_packer.sv
// rtl/ntt_lane_packer.sv - serial-to-parallel frame packer feeding the NTT datapath
// Optional feature macro: NTT_PACK_SOF_CHECK_EN (honour in_sof framing, report frame_err).
module ntt_lane_packer #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32,
  parameter int NTT_N                = 1024
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic                                            in_sof,
  input  logic [DATA_WIDTH_PER_INPUT-1:0]                 in_data,
  output logic                                            out_start,
  output logic                                            out_valid,
  output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] out_data,
  output logic                                            frame_err,
  output logic                                            busy
);

  localparam int DW   = DATA_WIDTH_PER_INPUT;
  localparam int P    = INPUT_PER_CYCLE;
  localparam int ROWS = NTT_N / P;
  localparam int WR_W = (NTT_N > 1) ? $clog2(NTT_N) : 1;
  localparam int RD_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LN_W = (P > 1) ? $clog2(P) : 1;

  localparam logic [WR_W-1:0] WR_LAST = WR_W'(NTT_N - 1);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(ROWS - 1);

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_start_q, out_start_d;
  logic [P*DW-1:0]   out_data_q, out_data_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;

  // Frame buffer: one row per parallel vector, lane j at bits [j*DW +: DW].
  logic [P*DW-1:0]   mem_q [ROWS];

  logic              accept;
  logic              seq_store;
  logic              wr_en;
  logic [WR_W-1:0]   wr_idx;
  logic [RD_W-1:0]   wr_row;
  logic [LN_W-1:0]   wr_lane;
  logic [P*DW-1:0]   row0_view;

`ifndef NTT_PACK_SOF_CHECK_EN
  logic              sof_unused;
  assign sof_unused = in_sof;
`endif

  // Ready is a decode of the state register, forced low while reset is held.
  assign in_ready = (state_q == ST_FILL) && !rst;
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_start = out_start_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

  // Natural-order placement: word k lands in row k/P, lane k%P.
  always_comb begin
    wr_row  = RD_W'(32'(wr_idx) / 32'(P));
    wr_lane = LN_W'(32'(wr_idx) % 32'(P));
  end

  // Row 0 as it will look after this cycle's write; only differs when the
  // whole frame fits in one row and the last word is still being written.
  always_comb begin
    row0_view = mem_q[0];
    if (ROWS == 1) begin
      row0_view[(P-1)*DW +: DW] = in_data;
    end
  end

  // Next-state, counters and registered-output inputs for the FILL/BURST FSM.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = 1'b0;
    out_start_d = 1'b0;
    out_data_d  = out_data_q;
    frame_err_d = 1'b0;
    seq_store   = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = wr_cnt_q;

    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          seq_store = 1'b1;
`ifdef NTT_PACK_SOF_CHECK_EN
          if (in_sof && (wr_cnt_q != '0)) begin
            // Early sof: abandon the partial frame and restart with this word.
            seq_store   = 1'b0;
            wr_en       = 1'b1;
            wr_idx      = '0;
            wr_cnt_d    = WR_W'(1);
            frame_err_d = 1'b1;
          end else if (!in_sof && (wr_cnt_q == '0)) begin
            // Frame must open with sof; anything else is dropped.
            seq_store   = 1'b0;
            frame_err_d = 1'b1;
          end
`endif
          if (seq_store) begin
            wr_en = 1'b1;
            if (wr_cnt_q == WR_LAST) begin
              // Frame complete: present row 0 next cycle, remaining rows follow.
              wr_cnt_d    = '0;
              rd_cnt_d    = (RD_LAST == '0) ? '0 : RD_W'(1);
              state_d     = ST_BURST;
              out_valid_d = 1'b1;
              out_start_d = 1'b1;
              out_data_d  = row0_view;
            end else begin
              wr_cnt_d = wr_cnt_q + WR_W'(1);
            end
          end
        end
      end

      ST_BURST: begin
        // rd_cnt holds the next row to load; 0 here means every row has gone out.
        if (rd_cnt_q == '0) begin
          state_d = ST_FILL;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = mem_q[rd_cnt_q];
          rd_cnt_d    = (rd_cnt_q == RD_LAST) ? '0 : rd_cnt_q + RD_W'(1);
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase

    busy_d = (state_d == ST_BURST);
  end

  // Control and output registers; reset discards any partial frame or burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_start_q <= out_start_d;
      out_data_q  <= out_data_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Buffer write port; stale contents are never shown because a burst only
  // starts after every word of the frame has been rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_row][wr_lane*DW +: DW] <= in_data;
    end
  end

endmodule

// File: tb/tb_ntt_lane_packer.sv
// tb/tb_ntt_lane_packer.sv - scoreboard bench for ntt_lane_packer
`timescale 1ns/1ps
module tb_ntt_lane_packer;

  localparam int DW   = 32;
  localparam int P    = 32;
  localparam int N    = 1024;
  localparam int ROWS = N / P;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_sof = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            out_start;
  logic            out_valid;
  logic [P*DW-1:0] out_data;
  logic            frame_err;
  logic            busy;

  ntt_lane_packer #(
    .DATA_WIDTH_PER_INPUT(DW),
    .INPUT_PER_CYCLE(P),
    .NTT_N(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sof(in_sof),
    .in_data(in_data),
    .out_start(out_start),
    .out_valid(out_valid),
    .out_data(out_data),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    int              row;
    bit              start;
    logic [P*DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            err_cyc_q[$];
  logic [DW-1:0] frame[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit prev_rst = 1'b0;
  bit armed = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_vec(int row, logic [P*DW-1:0] act, logic [P*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int j = 0; j < P; j++) begin
        if (act[j*DW +: DW] !== exp[j*DW +: DW]) begin
          $display("FAIL out_data cyc=%0d row=%0d lane=%0d actual=%0h required=%0h",
                   cyc, row, j, act[j*DW +: DW], exp[j*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // Reference model: collect accepted words; a full frame becomes ROWS vectors,
  // vector r lane j = word r*P+j, presented on consecutive cycles after the last accept.
  function automatic void model_accept(logic [DW-1:0] d, logic s);
`ifdef NTT_PACK_SOF_CHECK_EN
    if (s && frame.size() != 0) begin
      frame.delete();
      err_cyc_q.push_back(cyc + 1);
    end else if (!s && frame.size() == 0) begin
      err_cyc_q.push_back(cyc + 1);
      return;
    end
`else
    if (s === 1'bx) return;
`endif
    frame.push_back(d);
    if (frame.size() == N) begin
      for (int r = 0; r < ROWS; r++) begin
        exp_t e;
        e.cyc   = cyc + 1 + r;
        e.row   = r;
        e.start = (r == 0);
        for (int j = 0; j < P; j++) e.data[j*DW +: DW] = frame[r*P + j];
        sb.push_back(e);
      end
      frame.delete();
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    prev_rst = rst;
    if (rst) armed = 1'b1;
    if (cyc > 40000) begin
      errors++;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // Model side: observe the handshake just before the edge that will complete it.
  always @(negedge clk) begin
    if (rst) begin
      frame.delete();
      while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      while (err_cyc_q.size() > 0 && err_cyc_q[$] > cyc) void'(err_cyc_q.pop_back());
    end else if (in_valid && in_ready) begin
      model_accept(in_data, in_sof);
    end
  end

  // Monitor: compare every cycle against what the scoreboard says is due now.
  always @(negedge clk) begin
    bit   exp_vec;
    bit   exp_err;
    exp_t e;
    exp_vec = (sb.size() > 0) && (sb[0].cyc == cyc);
    if (rst) chk("in_ready_during_rst", in_ready, 0);
    if (armed) begin
      if (prev_rst) chk("out_data_after_rst", (out_data === '0) ? 64'd0 : 64'd1, 64'd0);
      chk("out_valid", out_valid, exp_vec);
      chk("busy", busy, exp_vec);
      if (!rst) chk("in_ready", in_ready, !exp_vec);
      exp_err = (err_cyc_q.size() > 0) && (err_cyc_q[0] == cyc);
      if (exp_err) void'(err_cyc_q.pop_front());
      chk("frame_err", frame_err, exp_err);
      if (exp_vec) begin
        e = sb.pop_front();
        chk("out_start", out_start, e.start);
        chk_vec(e.row, out_data, e.data);
      end else begin
        chk("out_start_idle", out_start, 0);
      end
    end
  end

  task automatic send_stream(int n, int base, int sof_a, int sof_b, bit gaps, output int stalls);
    int k = 0;
    stalls = 0;
    while (k < n) begin
      @(posedge clk);
      #1;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = DW'(base + k);
      in_sof   = (k == sof_a) || (k == sof_b);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      else if (in_valid) stalls++;
    end
  endtask

  task automatic go_idle(int n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Gap-free frame of 0..N-1, no burst in progress so no stalls.
    send_stream(N, 0, 0, -1, 1'b0, st);
    chk("stalls_first_frame", st, 0);

    // in_valid held high through the burst: exactly ROWS refused cycles.
    send_stream(N, 32'h2000, 0, -1, 1'b0, st);
    chk("stalls_during_burst", st, ROWS);

    // Random 50% gaps with 0x1000+k.
    send_stream(N, 32'h1000, 0, -1, 1'b1, st);

    // Reset while row 10 is on the output.
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fresh randomly-based frame with gaps after the reset.
    send_stream(N, int'($urandom), 0, -1, 1'b1, st);
    go_idle(ROWS + 2);

`ifdef NTT_PACK_SOF_CHECK_EN
    // Second sof at word 500 restarts the frame.
    send_stream(500 + N, 32'h3000, 0, 500, 1'b0, st);
    go_idle(ROWS + 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    // First word after reset lacks sof and must be dropped.
    send_stream(N + 1, 32'h4000, 1, -1, 1'b0, st);
    go_idle(ROWS + 2);
`endif

    go_idle(ROWS + 4);
    chk("scoreboard_drained", sb.size(), 0);
    chk("frame_err_drained", err_cyc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
